store_merge_buffer: RTL and testbench
=====================================

STORE_MERGE_BUFFER -- requirements
Module: store_merge_buffer

Interface
REQ-001 Parameter DEPTH, default 8: number of entries; a power of two from 2 to 16.
REQ-002 Parameter DATA_W, default 64: store word width; 32 or 64. BE_W = DATA_W/8, OFS = log2(BE_W).
REQ-003 Parameter PLEN, default 56: physical address width.
REQ-004 Parameter MERGE_EN, default 1: enables commit-time coalescing.
REQ-005 clk_i  in  1  clock; all logic is clocked on the rising edge.
REQ-006 rst_i  in  1  reset, asynchronous and active-high.
REQ-007 flush_i  in  1  drop all speculative entries.
REQ-008 valid_i / ready_o  in / out  1 / 1  store push handshake.
REQ-009 paddr_i, data_i, be_i  in  PLEN / DATA_W / BE_W  pushed store; data_i is already aligned.
REQ-010 commit_i / commit_ready_o  in / out  1 / 1  commit of the oldest speculative store.
REQ-011 mem_req_o / mem_gnt_i  out / in  1 / 1  write request to the cache.
REQ-012 mem_addr_o, mem_data_o, mem_be_o  out  PLEN / DATA_W / BE_W  request payload; mem_addr_o low OFS bits are zero.
REQ-013 page_offset_i / page_offset_match_o  in / out  12 / 1  load hazard check.
REQ-014 empty_o, committed_empty_o  out  1 / 1  no entries at all / no committed entries.

Function
REQ-015 Storage is one ring of DEPTH entries {paddr word, data, be} with three pointers: head, cptr (first speculative entry), tail. Counters n_all and n_com track occupancy.
REQ-016 ready_o = (n_all < DEPTH); a push occurs when valid_i && ready_o && !flush_i, writes the entry at tail, and the entry is speculative.
REQ-017 commit_ready_o = (n_all - n_com > 0); a commit occurs when commit_i && commit_ready_o and advances cptr by 1.
REQ-018 commit_i while commit_ready_o is low is ignored; the bench flags it as an assertion error.
REQ-019 Merge occurs when MERGE_EN, a commit occurs, n_com >= 2, the entry at cptr-1 has be != 0, and the word addresses of the entries at cptr-1 and cptr are equal.
REQ-020 On a merge, entry cptr-1 takes the new entry's bytes where the new entry's be is set, its be becomes the OR of both, and entry cptr has be cleared to become a bubble.
REQ-021 mem_req_o = (n_com > 0) && head.be != 0; the payload comes from the head entry.
REQ-022 The head entry pops on mem_gnt_i while mem_req_o is high.
REQ-023 A committed bubble at head pops in one cycle without a request.
REQ-024 The head entry's content is never modified while it is at head.
REQ-025 Flush sets tail = cptr and n_all = n_com; a commit in the same cycle applies first.
REQ-026 A push in the same cycle as a flush is discarded, and committed entries survive the flush.
REQ-027 Push, commit (with or without merge), and pop may all occur in the same cycle; counters update by their net effect, so a pop frees a slot one cycle after the grant.
REQ-028 page_offset_match_o is combinational: 1 if any entry in [head, tail) with be != 0 has paddr[11:OFS] == page_offset_i[11:OFS], or if valid_i && paddr_i[11:OFS] == page_offset_i[11:OFS].
REQ-029 Pointers wrap modulo DEPTH; full is n_all == DEPTH; no overflow and no underflow is possible.
REQ-030 empty_o = (n_all == 0); committed_empty_o = (n_com == 0).

Reset
REQ-031 While rst_i is high: all pointers and counters are 0, all be are 0, mem_req_o=0, ready_o=1, commit_ready_o=0, empty_o=1, committed_empty_o=1.
REQ-032 While rst_i is high, page_offset_match_o depends only on the current valid_i / paddr_i inputs.
REQ-033 Reset asserted mid-operation discards all entries, speculative and committed, and an in-flight request is dropped without completion.

Verification (DEPTH=4, DATA_W=64, MERGE_EN=1)
REQ-034 Fill and full: push 4 stores with no commit -> ready_o=0 after the 4th, commit_ready_o=1, mem_req_o=0; a 5th valid_i is not accepted.
REQ-035 Drain order: push A(0x1000, be=0x0F), B(0x2000), C(0x3000); commit 3 times; hold mem_gnt_i=1 -> requests go out in order 0x1000, 0x2000, 0x3000, then empty_o=1.
REQ-036 Merge, setup: push X(0x100, be=0x0F), Y(0x200), Z(0x200, data=0xAA00..., be=0xF0); hold gnt=0; commit 3 times.
REQ-037 Merge, check: Z folds into Y and becomes a bubble -> memory sees 0x100, then 0x200 with be=OR of Y and Z; 2 grants empty the buffer.
REQ-038 Flush: push 3 stores, commit 1, flush together with a 2nd commit -> n_all=2 and 2 requests are issued; the 3rd store never appears.
REQ-039 Hazard: entry at 0x80008 with page_offset_i=0x00C -> page_offset_match_o=1; page_offset_i=0x010 -> 0; after the entry drains, 0x00C -> 0.
REQ-040 Reset mid-drain: assert rst_i while mem_req_o=1 and gnt=0 -> mem_req_o=0 and empty_o=1 immediately; pushes are accepted again after release.

Source files
------------

// File: rtl/store_merge_buffer.sv
// Store buffer ring holding speculative and committed stores; committed stores
// to the same word are coalesced at commit time and drained to the cache in order.
module store_merge_buffer #(
   parameter int DEPTH    = 8,
   parameter int DATA_W   = 64,
   parameter int PLEN     = 56,
   parameter int MERGE_EN = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [PLEN-1:0]     paddr_i,
   input  logic [DATA_W-1:0]   data_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic                commit_i,
   output logic                commit_ready_o,
   output logic                mem_req_o,
   input  logic                mem_gnt_i,
   output logic [PLEN-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]   mem_data_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   input  logic [11:0]         page_offset_i,
   output logic                page_offset_match_o,
   output logic                empty_o,
   output logic                committed_empty_o
);

   localparam int BE_W = DATA_W / 8;
   localparam int OFS  = $clog2(BE_W);
   localparam int AW   = PLEN - OFS;
   localparam int POW  = 12 - OFS;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_TWO  = CW'(2);
   localparam logic [PW-1:0] P_ONE  = PW'(1);

   logic [AW-1:0]     addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [BE_W-1:0]   be_q   [DEPTH];

   logic [PW-1:0] head_q, cptr_q, tail_q, cprev;
   logic [CW-1:0] n_all_q, n_com_q, n_all_d, n_com_d;
   logic          push, commit, pop, merge;
   logic          unused_ofs;

   assign unused_ofs = ^{paddr_i[OFS-1:0], page_offset_i[OFS-1:0]};

   assign cprev             = cptr_q - P_ONE;
   assign ready_o           = n_all_q < FULL_C;
   assign commit_ready_o    = n_all_q != n_com_q;
   assign empty_o           = n_all_q == '0;
   assign committed_empty_o = n_com_q == '0;

   assign mem_req_o  = (n_com_q != '0) && (be_q[head_q] != '0);
   assign mem_addr_o = {addr_q[head_q], {OFS{1'b0}}};
   assign mem_data_o = data_q[head_q];
   assign mem_be_o   = be_q[head_q];

   assign push   = valid_i && ready_o && !flush_i;
   assign commit = commit_i && commit_ready_o;
   // A committed bubble (be == 0) at head retires without asking the cache.
   assign pop    = (n_com_q != '0) && ((be_q[head_q] == '0) || mem_gnt_i);
   // n_com >= 2 keeps the merge target away from head, whose content must stay stable.
   assign merge  = (MERGE_EN != 0) && commit && (n_com_q >= C_TWO) &&
                   (be_q[cprev] != '0) && (addr_q[cprev] == addr_q[cptr_q]);

   always_comb begin
      n_com_d = n_com_q;
      if (commit) n_com_d = n_com_d + C_ONE;
      if (pop)    n_com_d = n_com_d - C_ONE;
      n_all_d = n_all_q;
      if (push)   n_all_d = n_all_d + C_ONE;
      if (pop)    n_all_d = n_all_d - C_ONE;
      if (flush_i) n_all_d = n_com_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         cptr_q  <= '0;
         tail_q  <= '0;
         n_all_q <= '0;
         n_com_q <= '0;
         for (int i = 0; i < DEPTH; i++) be_q[i] <= '0;
      end else begin
         if (pop)    head_q <= head_q + P_ONE;
         if (commit) cptr_q <= cptr_q + P_ONE;
         if (flush_i)   tail_q <= commit ? cptr_q + P_ONE : cptr_q;
         else if (push) tail_q <= tail_q + P_ONE;
         n_all_q <= n_all_d;
         n_com_q <= n_com_d;
         if (push) be_q[tail_q] <= be_i;
         if (merge) begin
            be_q[cprev]  <= be_q[cprev] | be_q[cptr_q];
            be_q[cptr_q] <= '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_q[tail_q] <= paddr_i[PLEN-1:OFS];
         data_q[tail_q] <= data_i;
      end
      if (merge) begin
         for (int b = 0; b < BE_W; b++) begin
            if (be_q[cptr_q][b]) data_q[cprev][8*b +: 8] <= data_q[cptr_q][8*b +: 8];
         end
      end
   end

   always_comb begin : match_scan
      logic [PW-1:0] rel;
      page_offset_match_o = valid_i && (paddr_i[11:OFS] == page_offset_i[11:OFS]);
      for (int i = 0; i < DEPTH; i++) begin
         rel = PW'(i) - head_q;
         if ((CW'(rel) < n_all_q) && (be_q[i] != '0) &&
             (addr_q[i][POW-1:0] == page_offset_i[11:OFS]))
            page_offset_match_o = 1'b1;
      end
   end

endmodule

// File: tb/tb_store_merge_buffer.sv
// Bench for store_merge_buffer: directed scenarios with literal expectations plus a
// randomized run, all compared each cycle against a queue-based store buffer model.
module tb_store_merge_buffer;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 64;
   localparam int BE_W   = 8;
   localparam int OFS    = 3;
   localparam int PLEN   = 56;
   localparam int AW     = PLEN - OFS;

   logic              clk, rst, flush, valid, ready, commit, commit_ready;
   logic              mem_req, mem_gnt, page_match, empty, cempty;
   logic [PLEN-1:0]   paddr, mem_addr;
   logic [DATA_W-1:0] data, mem_data;
   logic [BE_W-1:0]   be, mem_be;
   logic [11:0]       page_offset;

   store_merge_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PLEN(PLEN), .MERGE_EN(1)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready),
      .paddr_i(paddr), .data_i(data), .be_i(be), .commit_i(commit),
      .commit_ready_o(commit_ready), .mem_req_o(mem_req), .mem_gnt_i(mem_gnt),
      .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_be_o(mem_be),
      .page_offset_i(page_offset), .page_offset_match_o(page_match),
      .empty_o(empty), .committed_empty_o(cempty)
   );

   typedef struct {
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] data;
      logic [BE_W-1:0]   be;
   } ent_t;

   // Model: queue ordered oldest first; the first ncom entries are committed.
   ent_t mq[$];
   int   ncom;
   int   n_checks, n_pass;

   logic              s_req, s_ready, s_cr, s_empty, s_match;
   logic [PLEN-1:0]   s_addr;
   logic [DATA_W-1:0] s_data;
   logic [BE_W-1:0]   s_be;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic modelMatch();
      logic m;
      m = valid && (paddr[11:OFS] == page_offset[11:OFS]);
      foreach (mq[i])
         if (mq[i].be != '0 && mq[i].addr[8:0] == page_offset[11:OFS]) m = 1'b1;
      return m;
   endfunction

   task automatic checkOutput();
      logic e_req;
      e_req = (ncom > 0) && (mq[0].be != '0);
      check("ready", 64'(ready), 64'(mq.size() < DEPTH));
      check("commit_ready", 64'(commit_ready), 64'(mq.size() > ncom));
      check("mem_req", 64'(mem_req), 64'(e_req));
      check("empty", 64'(empty), 64'(mq.size() == 0));
      check("committed_empty", 64'(cempty), 64'(ncom == 0));
      check("page_match", 64'(page_match), 64'(modelMatch()));
      if (e_req) begin
         check("mem_addr", 64'(mem_addr), 64'({mq[0].addr, 3'b000}));
         check("mem_data", mem_data, mq[0].data);
         check("mem_be", 64'(mem_be), 64'(mq[0].be));
      end
      if (!rst && commit && !commit_ready)
         $error("[TB] commit_i asserted while commit_ready_o low");
      s_req = mem_req; s_ready = ready; s_cr = commit_ready; s_empty = empty;
      s_match = page_match; s_addr = mem_addr; s_data = mem_data; s_be = mem_be;
   endtask

   task automatic modelStep();
      logic rdy, crd, popd;
      ent_t prev, cur;
      rdy  = mq.size() < DEPTH;
      crd  = mq.size() > ncom;
      popd = (ncom > 0) && ((mq[0].be == '0) || mem_gnt);
      if (commit && crd) begin
         if (ncom >= 2 && mq[ncom-1].be != '0 && mq[ncom-1].addr == mq[ncom].addr) begin
            prev = mq[ncom-1];
            cur  = mq[ncom];
            for (int b = 0; b < BE_W; b++)
               if (cur.be[b]) prev.data[8*b +: 8] = cur.data[8*b +: 8];
            prev.be = prev.be | cur.be;
            cur.be  = '0;
            mq[ncom-1] = prev;
            mq[ncom]   = cur;
         end
         ncom++;
      end
      if (flush)
         while (mq.size() > ncom) mq.delete(mq.size() - 1);
      if (valid && rdy && !flush) begin
         cur.addr = paddr[PLEN-1:OFS];
         cur.data = data;
         cur.be   = be;
         mq.push_back(cur);
      end
      if (popd) begin
         mq.delete(0);
         ncom--;
      end
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [PLEN-1:0] a,
                                input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b,
                                input logic c, input logic f, input logic g);
      @(negedge clk);
      rst = r; valid = v; paddr = a; data = d; be = b; commit = c; flush = f; mem_gnt = g;
      if (r) begin
         mq.delete();
         ncom = 0;
      end
      #1;
      checkOutput();
      @(posedge clk);
      if (!r) modelStep();
   endtask

   task automatic idle(input int n, input logic g);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, g);
   endtask

   task automatic pushStore(input logic [PLEN-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [BE_W-1:0] b);
      applyStimulus(1'b0, 1'b1, a, d, b, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic commitOne();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [PLEN-1:0]   addrs[$];
      logic [BE_W-1:0]   bes[$];
      logic [DATA_W-1:0] datas[$];
      logic [PLEN-1:0]   a;
      logic [DATA_W-1:0] d;
      logic [BE_W-1:0]   b;
      logic              r, v, c, f, g;

      rst = 1'b0; valid = 1'b0; paddr = '0; data = '0; be = '0;
      commit = 1'b0; flush = 1'b0; mem_gnt = 1'b0; page_offset = 12'h008;
      ncom = 0; n_checks = 0; n_pass = 0;

      // Reset state; match follows only the live push inputs.
      applyStimulus(1'b1, 1'b1, 56'h8, '0, '0, 1'b0, 1'b0, 1'b0);
      check("rst_ready_lit", 64'(s_ready), 64'd1);
      check("rst_commit_ready_lit", 64'(s_cr), 64'd0);
      check("rst_mem_req_lit", 64'(s_req), 64'd0);
      check("rst_empty_lit", 64'(s_empty), 64'd1);
      check("rst_match_input_lit", 64'(s_match), 64'd1);
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("rst_match_idle_lit", 64'(s_match), 64'd0);
      idle(1, 1'b0);

      // Fill and full.
      for (int i = 0; i < DEPTH; i++)
         pushStore(PLEN'(32'h4000 + i * 64), {$urandom, $urandom}, 8'hFF);
      pushStore(56'h5000, 64'h55, 8'hFF);
      check("full_ready_lit", 64'(s_ready), 64'd0);
      check("full_commit_ready_lit", 64'(s_cr), 64'd1);
      check("full_mem_req_lit", 64'(s_req), 64'd0);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
      idle(1, 1'b0);
      check("full_flushed_empty_lit", 64'(s_empty), 64'd1);

      // Drain order.
      pushStore(56'h1000, 64'h0A, 8'h0F);
      pushStore(56'h2000, 64'h0B, 8'hFF);
      pushStore(56'h3000, 64'h0C, 8'hFF);
      repeat (3) commitOne();
      addrs.delete();
      for (int i = 0; i < 6; i++) begin
         idle(1, 1'b1);
         if (s_req) addrs.push_back(s_addr);
      end
      check("drain_count_lit", 64'(addrs.size()), 64'd3);
      check("drain_addr0_lit", 64'(addrs.size() > 0 ? addrs[0] : '1), 64'h1000);
      check("drain_addr1_lit", 64'(addrs.size() > 1 ? addrs[1] : '1), 64'h2000);
      check("drain_addr2_lit", 64'(addrs.size() > 2 ? addrs[2] : '1), 64'h3000);
      check("drain_empty_lit", 64'(s_empty), 64'd1);

      // Merge: Z folds into Y.
      pushStore(56'h100, 64'h1111, 8'h0F);
      pushStore(56'h200, 64'h0000_0000_1122_3344, 8'h0F);
      pushStore(56'h200, 64'hAA00_0000_0000_0000, 8'hF0);
      repeat (3) commitOne();
      addrs.delete(); bes.delete(); datas.delete();
      for (int i = 0; i < 6; i++) begin
         idle(1, 1'b1);
         if (s_req) begin
            addrs.push_back(s_addr); bes.push_back(s_be); datas.push_back(s_data);
         end
      end
      check("merge_grants_lit", 64'(addrs.size()), 64'd2);
      check("merge_addr0_lit", 64'(addrs.size() > 0 ? addrs[0] : '1), 64'h100);
      check("merge_addr1_lit", 64'(addrs.size() > 1 ? addrs[1] : '1), 64'h200);
      check("merge_be1_lit", 64'(bes.size() > 1 ? bes[1] : '0), 64'hFF);
      check("merge_data1_lit", datas.size() > 1 ? datas[1] : '0, 64'hAA00_0000_1122_3344);
      check("merge_empty_lit", 64'(s_empty), 64'd1);

      // Flush together with a commit.
      pushStore(56'h600, 64'h6, 8'hFF);
      pushStore(56'h700, 64'h7, 8'hFF);
      pushStore(56'h800, 64'h8, 8'hFF);
      commitOne();
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
      idle(1, 1'b0);
      check("flush_commit_ready_lit", 64'(s_cr), 64'd0);
      check("flush_empty_lit", 64'(s_empty), 64'd0);
      addrs.delete();
      for (int i = 0; i < 6; i++) begin
         idle(1, 1'b1);
         if (s_req) addrs.push_back(s_addr);
      end
      check("flush_req_count_lit", 64'(addrs.size()), 64'd2);
      check("flush_addr1_lit", 64'(addrs.size() > 1 ? addrs[1] : '1), 64'h700);
      check("flush_drained_empty_lit", 64'(s_empty), 64'd1);

      // Load hazard.
      pushStore(56'h80008, 64'h9, 8'hFF);
      page_offset = 12'h00C;
      idle(1, 1'b0);
      check("hazard_hit_lit", 64'(s_match), 64'd1);
      page_offset = 12'h010;
      idle(1, 1'b0);
      check("hazard_miss_lit", 64'(s_match), 64'd0);
      commitOne();
      idle(3, 1'b1);
      page_offset = 12'h00C;
      idle(1, 1'b0);
      check("hazard_drained_lit", 64'(s_match), 64'd0);

      // Reset mid-drain.
      pushStore(56'h900, 64'h99, 8'hFF);
      commitOne();
      idle(1, 1'b0);
      check("midrst_req_before_lit", 64'(s_req), 64'd1);
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      check("midrst_req_lit", 64'(s_req), 64'd0);
      check("midrst_empty_lit", 64'(s_empty), 64'd1);
      pushStore(56'hA00, 64'hAA, 8'hFF);
      check("midrst_ready_lit", 64'(s_ready), 64'd1);
      idle(1, 1'b0);
      check("midrst_push_taken_lit", 64'(s_empty), 64'd0);

      // Randomized traffic over a small address set to provoke merges and hazards.
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 299) == 0);
         v = ($urandom_range(0, 99) < 60);
         a = '0;
         a[12]  = 1'($urandom_range(0, 1));
         a[4:3] = 2'($urandom_range(0, 3));
         a[2:0] = 3'($urandom);
         d = {$urandom, $urandom};
         b = 8'($urandom);
         if ($urandom_range(0, 9) == 0) b = '0;
         c = (mq.size() > ncom) && ($urandom_range(0, 99) < 50) && !r;
         f = ($urandom_range(0, 99) < 3);
         g = ($urandom_range(0, 99) < 50);
         page_offset = {7'b0, 2'($urandom_range(0, 3)), 3'($urandom)};
         applyStimulus(r, v, a, d, b, c, f, g);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
